// File: rtl/chunked_addsub.sv
// Multi-cycle two's-complement adder/subtractor: a WIDTH-bit add or subtract
// handled CHUNK bits per clock, with the inter-chunk carry held in a register.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             msb_cin;

  // Operands shift right one chunk per cycle and results shift in at the top,
  // so the active chunk always sits at [CHUNK-1:0] and no variable slicing is needed.
  always_comb begin
    chunk_a = op_a_q[CHUNK-1:0];
    chunk_b = op_b_q[CHUNK-1:0];
    {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk's top bit, recovered from its sum bit.
    msb_cin = chunk_s[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sum_d      = sum_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          op_a_d  = a;
          op_b_d  = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          acc_d   = '0;
        end
      end

      RUN: begin
        op_a_d  = op_a_q >> CHUNK;
        op_b_d  = op_b_q >> CHUNK;
        acc_d   = (acc_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
        carry_d = chunk_c;
        if (idx_q == LAST_IDX) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          idx_d      = '0;
          sum_d      = acc_d;
          carryout_d = chunk_c;
          overflow_d = msb_cin ^ chunk_c;
          zero_d     = (acc_d == '0);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule
